systolic_feeder: RTL



---
 rtl/systolic_feeder.sv | 132 +++++++++++++
 1 files changed

// File: rtl/systolic_feeder.sv
// Edge-operand feeder for an N x N systolic array: buffers A and B, then streams them skewed.
// Define SYSTOLIC_FEEDER_BT_EN to store B writes transposed (element k -> Bbuf[k][i_wrIdx]).
module systolic_feeder #(
    parameter int unsigned N     = 16,
    parameter int unsigned DRAIN = 1
) (
    input  logic                       i_clk,
    input  logic                       i_arst_n,
    input  logic                       i_wrValid,
    output logic                       o_wrReady,
    input  logic                       i_wrSel,
    input  logic [$clog2(N)-1:0]       i_wrIdx,
    input  logic [N-1:0][7:0]          i_wrData,
    input  logic                       i_start,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_doProcess,
    output logic [N-1:0][2*N-2:0][7:0] o_row,
    output logic [N-1:0][2*N-2:0][7:0] o_col
);

    localparam int unsigned R  = 3 * N - 2 + DRAIN;
    localparam int unsigned CW = $clog2(R);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLoad = 2'd1;
    localparam logic [1:0] StRun  = 2'd2;

    logic [1:0]                 state_q, state_d;
    logic [CW-1:0]              step_q, step_d;
    logic                       done_q, done_d;
    logic [N-1:0][N-1:0][7:0]   abuf_q, abuf_d;
    logic [N-1:0][N-1:0][7:0]   bbuf_q, bbuf_d;
    logic [N-1:0][2*N-2:0][7:0] row_sr_q, row_sr_d;
    logic [N-1:0][2*N-2:0][7:0] col_sr_q, col_sr_d;

    always_comb begin
        abuf_d = abuf_q;
        bbuf_d = bbuf_q;
        if (i_wrValid) begin
            if (!i_wrSel) begin
                abuf_d[i_wrIdx] = i_wrData;
            end else begin
`ifdef SYSTOLIC_FEEDER_BT_EN
                for (int k = 0; k < N; k++) begin
                    bbuf_d[k][i_wrIdx] = i_wrData[k];
                end
`else
                bbuf_d[i_wrIdx] = i_wrData;
`endif
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        done_d   = 1'b0;
        row_sr_d = row_sr_q;
        col_sr_d = col_sr_q;
        case (state_q)
            StIdle: begin
                row_sr_d = '0;
                col_sr_d = '0;
                step_d   = '0;
                if (i_start) state_d = StLoad;
            end
            StLoad: begin
                // Snapshot uses the post-write buffer so a write on this edge is included.
                row_sr_d = '0;
                col_sr_d = '0;
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        row_sr_d[i][i+j] = abuf_d[i][j];
                        col_sr_d[j][i+j] = bbuf_d[i][j];
                    end
                end
                step_d  = '0;
                state_d = StRun;
            end
            StRun: begin
                if (step_q == CW'(R - 1)) begin
                    row_sr_d = '0;
                    col_sr_d = '0;
                    step_d   = '0;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end else begin
                    step_d = step_q + 1'b1;
                    for (int i = 0; i < N; i++) begin
                        row_sr_d[i] = {8'h00, row_sr_q[i][2*N-2:1]};
                        col_sr_d[i] = {8'h00, col_sr_q[i][2*N-2:1]};
                    end
                end
            end
            default: begin
                row_sr_d = '0;
                col_sr_d = '0;
                step_d   = '0;
                state_d  = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q  <= StIdle;
            step_q   <= '0;
            done_q   <= 1'b0;
            abuf_q   <= '0;
            bbuf_q   <= '0;
            row_sr_q <= '0;
            col_sr_q <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            done_q   <= done_d;
            abuf_q   <= abuf_d;
            bbuf_q   <= bbuf_d;
            row_sr_q <= row_sr_d;
            col_sr_q <= col_sr_d;
        end
    end

    assign o_wrReady   = i_arst_n;
    assign o_busy      = (state_q != StIdle);
    assign o_doProcess = (state_q == StRun);
    assign o_done      = done_q;
    assign o_row       = row_sr_q;
    assign o_col       = col_sr_q;

endmodule
